// File: rtl/store_buffer_pkg.sv
// Shared types and sizes for the posted-write store buffer.
// Entry record, pointer/count types and a word-address compare helper.
package store_buf_pkg;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic          sb;
  } sbuf_entry_t;

  // Loads and stores alias when they touch the same 32-bit word.
  function automatic logic word_eq(
    input logic [AW-1:0] a,
    input logic [AW-1:0] b
  );
    return a[AW-1:2] == b[AW-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and dmem-side signals of the store buffer.
// slave: the buffer itself; master: core + dmem environment.
interface store_buffer_if;
  import store_buf_pkg::*;

  logic          cpu_memwrite;
  logic          cpu_sb;
  logic          cpu_memread;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_we;
  logic          mem_sb;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  cpu_memwrite, cpu_sb, cpu_memread,
    input  cpu_adr, cpu_wdata,
    input  mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall,
    output mem_we, mem_sb, mem_adr,
    output mem_wdata, mem_raddr
  );

  modport master (
    output cpu_memwrite, cpu_sb, cpu_memread,
    output cpu_adr, cpu_wdata,
    output mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall,
    input  mem_we, mem_sb, mem_adr,
    input  mem_wdata, mem_raddr
  );

endinterface

// File: rtl/store_buffer_match.sv
// sbuf_match: word-address compare of a load against all valid entries.
// Ports: ent/vld/wr_ptr (buffer state), adr (load) -> hit, hit_idx, hit_sb.
module sbuf_match
  import store_buf_pkg::*;
(
  input  sbuf_entry_t [DEPTH-1:0] ent,
  input  logic [DEPTH-1:0]        vld,
  input  ptr_t                    wr_ptr,
  input  logic [AW-1:0]           adr,
  output logic                    hit,
  output ptr_t                    hit_idx,
  output logic                    hit_sb
);

  ptr_t idx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_sb  = 1'b0;
    idx     = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - ptr_t'(k);
      if (vld[idx] && word_eq(ent[idx].adr, adr)) begin
        hit     = 1'b1;
        hit_idx = idx;
        hit_sb  = ent[idx].sb;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between core and dmem with load check.
// Ports: clk, reset (async, active-low), bus (store_buffer_if.slave), count.
// Build option: STORE_BUF_FWD_EN forwards youngest word-store data to loads.
module store_buffer
  import store_buf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  store_buffer_if.slave        bus,
  output cnt_t                 count
);

  sbuf_entry_t [DEPTH-1:0] ent_q;
  logic [DEPTH-1:0]        vld_q;
  ptr_t                    rd_ptr;
  ptr_t                    wr_ptr;
  cnt_t                    cnt_q;

  logic        empty;
  logic        full;
  logic        deq;
  logic        enq;
  logic        is_load;
  logic        hit;
  ptr_t        hit_idx;
  logic        hit_sb;
  logic        load_hazard;
  sbuf_entry_t head;

  sbuf_match u_match (
    .ent     (ent_q),
    .vld     (vld_q),
    .wr_ptr  (wr_ptr),
    .adr     (bus.cpu_adr),
    .hit     (hit),
    .hit_idx (hit_idx),
    .hit_sb  (hit_sb)
  );

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == cnt_t'(DEPTH));
  assign head    = ent_q[rd_ptr];
  assign deq     = ~empty & bus.mem_ready;
  // A store wins over a simultaneous load.
  assign is_load = bus.cpu_memread & ~bus.cpu_memwrite;

`ifdef STORE_BUF_FWD_EN
  assign load_hazard = is_load & hit & hit_sb;
  assign bus.cpu_rdata =
    (is_load & hit & ~hit_sb) ? ent_q[hit_idx].data
                              : bus.mem_rdata;
`else
  assign load_hazard = is_load & hit;
  assign bus.cpu_rdata = bus.mem_rdata;
`endif

  // A full buffer still accepts a store when the head leaves this cycle.
  assign bus.cpu_stall =
    (bus.cpu_memwrite & full & ~deq) | load_hazard;
  assign enq = bus.cpu_memwrite & ~bus.cpu_stall;

  assign bus.mem_we    = ~empty;
  assign bus.mem_sb    = head.sb;
  assign bus.mem_adr   = head.adr;
  assign bus.mem_wdata = head.data;
  assign bus.mem_raddr = bus.cpu_adr;
  assign count         = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q  <= '0;
      vld_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      // Clear before set: on a full enq+deq both hit the same slot.
      if (deq) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (enq) begin
        ent_q[wr_ptr] <= '{adr:  bus.cpu_adr,
                           data: bus.cpu_wdata,
                           sb:   bus.cpu_sb};
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      unique case ({enq, deq})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Vector table for single-cycle behaviour plus reset and wrap sequences.
module tb_store_buffer;
  import store_buf_pkg::*;

  logic clk;
  logic rst_n;
  cnt_t count;

  store_buffer_if sbif ();

  store_buffer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (sbif),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        sb;
    logic        r;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] mrd;
    logic        rdy;
    logic        e_stall;
    logic [31:0] e_rdata;
    int          e_cnt;
    logic        e_we;
    logic [31:0] e_adr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[64];
  int   n;
  int   errors;
  int   checks;

  localparam logic [31:0] MR = 32'hDEAD0000;

  task automatic add(
    input logic w, input logic sb, input logic r,
    input logic [31:0] adr, input logic [31:0] wd,
    input logic [31:0] mrd, input logic rdy,
    input logic e_stall, input logic [31:0] e_rdata,
    input int e_cnt, input logic e_we,
    input logic [31:0] e_adr, input logic [31:0] e_wd
  );
    vecs[n] = '{w, sb, r, adr, wd, mrd, rdy,
                e_stall, e_rdata, e_cnt, e_we, e_adr, e_wd};
    n++;
  endtask

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(
    input logic w, input logic sb, input logic r,
    input logic [31:0] adr, input logic [31:0] wd,
    input logic [31:0] mrd, input logic rdy
  );
    sbif.cpu_memwrite = w;
    sbif.cpu_sb       = sb;
    sbif.cpu_memread  = r;
    sbif.cpu_adr      = adr;
    sbif.cpu_wdata    = wd;
    sbif.mem_rdata    = mrd;
    sbif.mem_ready    = rdy;
  endtask

  logic [63:0] q[$];
  int          mcnt;
  int          issued;
  logic        mw;
  logic        mrdy;
  logic        mdeq;
  logic        mstall;
  logic [63:0] front;

  initial begin
    errors = 0;
    checks = 0;
    n      = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 0, MR, 0);

    // store/load/addr/wdata/mrdata/ready | stall/rdata/cnt/we/adr/wd
    add(1,0,0,32'h54,32'h11,MR,1, 0,MR,0,0,0,0);
    add(0,0,0,0,0,MR,1,           0,MR,1,1,32'h54,32'h11);
    add(0,0,0,0,0,MR,1,           0,MR,0,0,0,0);
    add(1,0,0,32'h100,1,MR,0,     0,MR,0,0,0,0);
    add(1,0,0,32'h104,2,MR,0,     0,MR,1,1,32'h100,1);
    add(1,0,0,32'h108,3,MR,0,     0,MR,2,1,32'h100,1);
    add(1,0,0,32'h10C,4,MR,0,     0,MR,3,1,32'h100,1);
    add(1,0,0,32'h110,5,MR,0,     1,MR,4,1,32'h100,1);
    add(1,0,0,32'h110,5,MR,1,     0,MR,4,1,32'h100,1);
    add(0,0,0,0,0,MR,1,           0,MR,4,1,32'h104,2);
    add(0,0,0,0,0,MR,1,           0,MR,3,1,32'h108,3);
    add(0,0,0,0,0,MR,1,           0,MR,2,1,32'h10C,4);
    add(0,0,0,0,0,MR,1,           0,MR,1,1,32'h110,5);
    add(0,0,0,0,0,MR,1,           0,MR,0,0,0,0);
    add(1,1,0,32'h81,7,MR,0,      0,MR,0,0,0,0);
    add(0,0,1,32'h80,0,32'h12345678,0,
        1,32'h12345678,1,1,32'h81,7);
    add(0,0,1,32'h80,0,32'h12345678,1,
        1,32'h12345678,1,1,32'h81,7);
    add(0,0,1,32'h80,0,32'h12345678,0,
        0,32'h12345678,0,0,0,0);
`ifdef STORE_BUF_FWD_EN
    add(1,0,0,32'h80,32'hCAFEBABE,MR,0, 0,MR,0,0,0,0);
    add(0,0,1,32'h80,0,32'h55,0,
        0,32'hCAFEBABE,1,1,32'h80,32'hCAFEBABE);
    add(1,0,0,32'h80,1,MR,0, 0,MR,1,1,32'h80,32'hCAFEBABE);
    add(1,0,0,32'h80,2,MR,0, 0,MR,2,1,32'h80,32'hCAFEBABE);
    add(0,0,1,32'h80,0,32'h55,0,
        0,32'h2,3,1,32'h80,32'hCAFEBABE);
    add(0,0,0,0,0,MR,1, 0,MR,3,1,32'h80,32'hCAFEBABE);
    add(0,0,0,0,0,MR,1, 0,MR,2,1,32'h80,1);
    add(0,0,0,0,0,MR,1, 0,MR,1,1,32'h80,2);
    add(0,0,0,0,0,MR,1, 0,MR,0,0,0,0);
`else
    add(1,0,0,32'h40,32'hAA,MR,0, 0,MR,0,0,0,0);
    add(0,0,1,32'h40,0,32'h55,0,  1,32'h55,1,1,32'h40,32'hAA);
    add(0,0,1,32'h44,0,32'h55,0,  0,32'h55,1,1,32'h40,32'hAA);
    add(0,0,1,32'h40,0,32'h55,1,  1,32'h55,1,1,32'h40,32'hAA);
    add(0,0,1,32'h40,0,32'h55,0,  0,32'h55,0,0,0,0);
`endif
    add(1,0,1,32'h300,32'h33,MR,0, 0,MR,0,0,0,0);
    add(0,0,0,0,0,MR,1,            0,MR,1,1,32'h300,32'h33);
    add(0,0,0,0,0,MR,1,            0,MR,0,0,0,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 0, 32'(count), 0);
    chk("rst_we", 0, 32'(sbif.mem_we), 0);
    chk("rst_stall", 0, 32'(sbif.cpu_stall), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < n; i++) begin
      drive(vecs[i].w, vecs[i].sb, vecs[i].r, vecs[i].adr,
            vecs[i].wd, vecs[i].mrd, vecs[i].rdy);
      @(negedge clk);
      chk("stall", i, 32'(sbif.cpu_stall), 32'(vecs[i].e_stall));
      chk("rdata", i, sbif.cpu_rdata, vecs[i].e_rdata);
      chk("count", i, 32'(count), vecs[i].e_cnt);
      chk("mem_we", i, 32'(sbif.mem_we), 32'(vecs[i].e_we));
      chk("raddr", i, sbif.mem_raddr, vecs[i].adr);
      if (vecs[i].e_we) begin
        chk("mem_adr", i, sbif.mem_adr, vecs[i].e_adr);
        chk("mem_wdata", i, sbif.mem_wdata, vecs[i].e_wd);
      end
      @(posedge clk);
      #1;
    end

    // Reset while draining three pending stores.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 32'h500 + 32'(4 * k), 32'h50 + 32'(k), MR, 0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, MR, 1);
    @(posedge clk);
    #1;
    chk("mid_count", 0, 32'(count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 0, 32'(count), 0);
    chk("arst_we", 0, 32'(sbif.mem_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("post_we", k, 32'(sbif.mem_we), 0);
      chk("post_count", k, 32'(count), 0);
    end

    // 3*DEPTH stores against a scoreboard with irregular mem_ready.
    mcnt   = 0;
    issued = 0;
    for (int c = 0; c < 200; c++) begin
      if (issued == 3 * DEPTH && mcnt == 0) break;
      mw   = (issued < 3 * DEPTH);
      mrdy = (c % 3 != 0);
      drive(mw, 0, 0, 32'h400 + 32'(4 * issued),
            32'hA000 + 32'(issued), MR, mrdy);
      @(negedge clk);
      mdeq   = (mcnt != 0) && mrdy;
      mstall = mw && (mcnt == DEPTH) && !mdeq;
      chk("wrap_stall", c, 32'(sbif.cpu_stall), 32'(mstall));
      chk("wrap_count", c, 32'(count), mcnt);
      chk("wrap_we", c, 32'(sbif.mem_we), 32'(mcnt != 0));
      if (mdeq) begin
        front = q.pop_front();
        chk("wrap_adr", c, sbif.mem_adr, front[63:32]);
        chk("wrap_wdata", c, sbif.mem_wdata, front[31:0]);
        mcnt--;
      end
      if (mw && !mstall) begin
        q.push_back({32'h400 + 32'(4 * issued),
                     32'hA000 + 32'(issued)});
        issued++;
        mcnt++;
      end
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, MR, 1);
    chk("wrap_issued", 0, 32'(issued), 3 * DEPTH);
    chk("wrap_drained", 0, 32'(mcnt), 0);
    @(negedge clk);
    chk("wrap_final", 0, 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
